// File: rtl/tristate_line_receiver_if.sv
// Interface bundle for tristate_line_receiver.
//   line     : shared single-wire tri-state line (released driver = Z)
//   data     : last good frame payload
//   valid    : data holds an unconsumed frame
//   ready    : consumer accepts data when valid && ready at a clk edge
//   busy     : receiver is inside a frame
//   err_col  : one-cycle pulse, X sampled on line (contention)
//   err_frm  : one-cycle pulse, stop bit read as 0
//   err_ovr  : one-cycle pulse, good frame dropped because valid still high
//   err_par  : one-cycle pulse, parity mismatch (0 unless RX_PARITY_EN)
// master = receiver side, slave = line driver / consumer side.
interface tristate_line_receiver_if #(
  parameter int unsigned DATA_W = 8
);
  logic              line;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              busy;
  logic              err_col;
  logic              err_frm;
  logic              err_ovr;
  logic              err_par;

  modport master (
    input  line, ready,
    output data, valid, busy, err_col, err_frm, err_ovr, err_par
  );

  modport slave (
    output line, ready,
    input  data, valid, busy, err_col, err_frm, err_ovr, err_par
  );
endinterface

// File: rtl/tristate_line_receiver.sv
// tristate_line_receiver
// Receive endpoint of a shared single-wire tri-state line. Recovers
// start / DATA_W data bits (LSB first) / [even parity] / stop frames by
// mid-bit sampling and presents each byte on a valid/ready handshake.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : tristate_line_receiver_if.master (line, data, valid, ready,
//           busy, err_col, err_frm, err_ovr, err_par)
// Parameters: DATA_W data bits per frame, OSR clocks per bit (even, >= 2).
// Build option: define RX_PARITY_EN to add an even-parity bit after the
// data bits; otherwise err_par is tied 0.
module tristate_line_receiver #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OSR    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  tristate_line_receiver_if.master  bus
);

  localparam int unsigned PH_W  = $clog2(OSR);
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(OSR / 2 - 1);
  localparam logic [PH_W-1:0]  PH_FULL  = PH_W'(OSR - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  state_t            state_q;
  logic [PH_W-1:0]   phase_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              busy_q;
  logic              err_col_q;
  logic              err_frm_q;
  logic              err_ovr_q;
  logic              err_par_q;
`ifdef RX_PARITY_EN
  logic              par_bad_q;
`endif

  // Line decode: 0 -> dominant zero, 1/Z -> recessive one, X -> collision.
  // The inner casez lets a Z on line match the wildcard while X does not.
  logic line_zero;
  logic line_col;

  always_comb begin
    line_zero = 1'b0;
    line_col  = 1'b0;
    case (bus.line)
      1'b0:    line_zero = 1'b1;
      1'b1:    line_zero = 1'b0;
      default: begin
        casez (bus.line)
          1'b1:    line_col = 1'b0;
          default: line_col = 1'b1;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_col_q <= 1'b0;
      err_frm_q <= 1'b0;
      err_ovr_q <= 1'b0;
      err_par_q <= 1'b0;
`ifdef RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      err_col_q <= 1'b0;
      err_frm_q <= 1'b0;
      err_ovr_q <= 1'b0;
      err_par_q <= 1'b0;

      // Consumer handshake; a delivery in ST_STOP below overrides this.
      if (valid_q && bus.ready) valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (line_zero) begin
            state_q <= ST_START;
            phase_q <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b1;
`ifdef RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
          end
        end

        ST_START: begin
          if (phase_q == PH_HALF) begin
            phase_q <= '0;
            if (line_col) begin
              err_col_q <= 1'b1;
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
            end else if (line_zero) begin
              state_q <= ST_DATA;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end

        ST_DATA: begin
          if (phase_q == PH_FULL) begin
            phase_q <= '0;
            if (line_col) begin
              err_col_q <= 1'b1;
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
            end else begin
              shift_q <= {~line_zero, shift_q[DATA_W-1:1]};
              bit_q   <= bit_q + BIT_W'(1);
              if (bit_q == BIT_LAST) begin
`ifdef RX_PARITY_EN
                state_q <= ST_PAR;
`else
                state_q <= ST_STOP;
`endif
              end
            end
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end

`ifdef RX_PARITY_EN
        ST_PAR: begin
          if (phase_q == PH_FULL) begin
            phase_q <= '0;
            if (line_col) begin
              err_col_q <= 1'b1;
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
            end else begin
              // Even parity: payload XOR parity bit must be 0.
              par_bad_q <= ^{shift_q, ~line_zero};
              err_par_q <= ^{shift_q, ~line_zero};
              state_q   <= ST_STOP;
            end
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
`endif

        ST_STOP: begin
          if (phase_q == PH_FULL) begin
            phase_q <= '0;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (line_col) begin
              err_col_q <= 1'b1;
            end else if (line_zero) begin
              err_frm_q <= 1'b1;
            end else begin
`ifdef RX_PARITY_EN
              if (!par_bad_q) begin
`else
              begin
`endif
                if (!valid_q || bus.ready) begin
                  data_q  <= shift_q;
                  valid_q <= 1'b1;
                end else begin
                  err_ovr_q <= 1'b1;
                end
              end
            end
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data    = data_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
  assign bus.err_col = err_col_q;
  assign bus.err_frm = err_frm_q;
  assign bus.err_ovr = err_ovr_q;
  assign bus.err_par = err_par_q;

endmodule
